// File: rtl/vram_fill_controller_if.sv
// Handshake/bus bundle for vram_fill_controller: fill config/status, CPU side and VRAM side.
// slave = the controller; master = the agent driving config/CPU and returning VRAM read data.
interface vram_fill_controller_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              cfg_start;
    logic              cfg_abort;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_len;
    logic [7:0]        cfg_step;
    logic [DATA_W-1:0] cfg_value;

    logic              busy;
    logic              done;
    logic              err;
    logic              aborted;
    logic [ADDR_W-1:0] remaining;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_d;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_q;

    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_d;
    logic              vram_we;
    logic [DATA_W-1:0] vram_q;

    modport slave (
        input  cfg_start, cfg_abort, cfg_base, cfg_len, cfg_step, cfg_value,
        input  cpu_req, cpu_addr, cpu_d, cpu_we, vram_q,
        output busy, done, err, aborted, remaining,
        output cpu_q, vram_addr, vram_d, vram_we
    );

    modport master (
        output cfg_start, cfg_abort, cfg_base, cfg_len, cfg_step, cfg_value,
        output cpu_req, cpu_addr, cpu_d, cpu_we, vram_q,
        input  busy, done, err, aborted, remaining,
        input  cpu_q, vram_addr, vram_d, vram_we
    );
endinterface

// File: rtl/vram_fill_controller.sv
// Strided constant-fill engine sharing one VRAM CPU port; first write 2 cycles after start, done 1 cycle after last write.
// The CPU always wins the port: the engine stalls (holds cur/remaining) in any cycle with cpu_req high.
module vram_fill_controller #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int WORDS  = 8194
) (
    input  logic                  clk,
    input  logic                  reset,
    vram_fill_controller_if.slave bus
);
    localparam int EXT_W = ADDR_W + 9;
    localparam logic [EXT_W-1:0] LAST_ADDR = EXT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FILL,
        FINISH
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [7:0]        step_q;
    logic [DATA_W-1:0] value_q;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] rem_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              aborted_q;

    logic [EXT_W-1:0]  end_addr_d;
    logic              range_bad_d;
    logic              engine_wr_d;

    // Widened so (len-1)*step can never wrap before the bound compare.
    always_comb begin
        end_addr_d  = EXT_W'(base_q) + EXT_W'(len_q - ADDR_W'(1)) * EXT_W'(step_q);
        range_bad_d = (end_addr_d > LAST_ADDR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            step_q    <= '0;
            value_q   <= '0;
            cur_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cfg_start && !bus.cfg_abort) begin
                        base_q  <= bus.cfg_base;
                        len_q   <= bus.cfg_len;
                        step_q  <= bus.cfg_step;
                        value_q <= bus.cfg_value;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (bus.cfg_abort) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (len_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else if (range_bad_d) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cur_q   <= base_q;
                        rem_q   <= len_q;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (bus.cfg_abort) begin
                        aborted_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (!bus.cpu_req) begin
                        cur_q <= cur_q + ADDR_W'(step_q);
                        rem_q <= rem_q - ADDR_W'(1);
                        if (rem_q == ADDR_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign engine_wr_d = (state_q == FILL) && !bus.cpu_req;

    // Write enable is gated by reset so an in-flight engine write never lands.
    always_comb begin
        bus.vram_addr = bus.cpu_addr;
        bus.vram_d    = bus.cpu_d;
        bus.vram_we   = bus.cpu_we;
        if (engine_wr_d) begin
            bus.vram_addr = cur_q;
            bus.vram_d    = value_q;
            bus.vram_we   = 1'b1;
        end
        if (reset) begin
            bus.vram_we = 1'b0;
        end
    end

    assign bus.cpu_q     = bus.vram_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.aborted   = aborted_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_vram_fill_controller.sv
// Directed bench for vram_fill_controller: engine writes are checked against a queue of expected
// (addr, data, cycle) entries; per-cycle status is checked against bit masks indexed by cycle offset.
module tb_vram_fill_controller;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle = 0;
    int   t0;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t eng_q[$];
    int  rem_e[$];

    vram_fill_controller_if #(.ADDR_W(14), .DATA_W(8)) bus ();

    vram_fill_controller #(.ADDR_W(14), .DATA_W(8), .WORDS(8194)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input int addr, input int data, input int cyc);
        wr_t w;
        w.addr = 14'(addr);
        w.data = 8'(data);
        w.cyc  = cyc;
        eng_q.push_back(w);
    endtask

    // Write monitor: CPU cycles must pass through, any other write must be the next expected engine write.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cpu_req) begin
                chk("cpu_pass_addr", 32'(bus.vram_addr), 32'(bus.cpu_addr));
                chk("cpu_pass_data", 32'(bus.vram_d), 32'(bus.cpu_d));
                chk("cpu_pass_we", 32'(bus.vram_we), 32'(bus.cpu_we));
                chk("cpu_q", 32'(bus.cpu_q), 32'(bus.vram_q));
            end else if (bus.vram_we) begin
                chk("engine_write_expected", 32'(eng_q.size() != 0), 32'd1);
                if (eng_q.size() != 0) begin
                    wr_t w;
                    w = eng_q.pop_front();
                    chk("engine_addr", 32'(bus.vram_addr), 32'(w.addr));
                    chk("engine_data", 32'(bus.vram_d), 32'(w.data));
                    chk("engine_cycle", 32'(cycle), 32'(w.cyc));
                end
            end
        end
    end

    // Drives cycles 0..n-1 from masks (bit k = cycle k) and checks the status outputs of each cycle.
    task automatic run(input int n, input logic [15:0] st_m, input logic [15:0] ab_m,
                       input logic [15:0] rq_m, input logic [15:0] busy_m, input logic [15:0] done_m,
                       input logic [15:0] err_m, input logic [15:0] abt_m);
        for (int k = 0; k < n; k++) begin
            bus.cfg_start = st_m[k];
            bus.cfg_abort = ab_m[k];
            bus.cpu_req   = rq_m[k];
            bus.cpu_we    = rq_m[k];
            bus.vram_q    = 8'(k * 17 + 3);
            @(negedge clk);
            chk($sformatf("busy@%0d", k), 32'(bus.busy), 32'(busy_m[k]));
            chk($sformatf("done@%0d", k), 32'(bus.done), 32'(done_m[k]));
            chk($sformatf("err@%0d", k), 32'(bus.err), 32'(err_m[k]));
            chk($sformatf("aborted@%0d", k), 32'(bus.aborted), 32'(abt_m[k]));
            if (k < rem_e.size() && rem_e[k] >= 0)
                chk($sformatf("remaining@%0d", k), 32'(bus.remaining), 32'(rem_e[k]));
            @(posedge clk);
            #1;
        end
        bus.cfg_start = 1'b0;
        bus.cfg_abort = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
    endtask

    task automatic cfg(input int base, input int len, input int step, input int value);
        bus.cfg_base  = 14'(base);
        bus.cfg_len   = 14'(len);
        bus.cfg_step  = 8'(step);
        bus.cfg_value = 8'(value);
    endtask

    initial begin
        reset         = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_abort = 1'b0;
        cfg(0, 0, 0, 0);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 14'h0055;
        bus.cpu_d     = 8'hEE;
        bus.vram_q    = 8'h00;
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_aborted", 32'(bus.aborted), 32'd0);
        chk("rst_remaining", 32'(bus.remaining), 32'd0);
        chk("rst_vram_we", 32'(bus.vram_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 14'h3FFF;
        bus.cpu_d    = 8'h11;
        @(posedge clk);
        #1;

        // Plain 4-word fill.
        cfg(14'h100, 4, 1, 8'hA5);
        t0 = cycle;
        for (int i = 0; i < 4; i++) push_wr(14'h100 + i, 8'hA5, t0 + 2 + i);
        rem_e = '{0, 0, 4, 3, 2, 1, 0, 0};
        run(8, 16'h0001, 16'h0000, 16'h0000, 16'h007E, 16'h0040, 16'h0000, 16'h0000);

        // Same fill with CPU writes in cycles 3-4 stalling the engine.
        t0 = cycle;
        push_wr(14'h100, 8'hA5, t0 + 2);
        push_wr(14'h101, 8'hA5, t0 + 5);
        push_wr(14'h102, 8'hA5, t0 + 6);
        push_wr(14'h103, 8'hA5, t0 + 7);
        rem_e = '{0, 0, 4, 3, 3, 3, 2, 1, 0, 0};
        run(10, 16'h0001, 16'h0000, 16'h0018, 16'h01FE, 16'h0100, 16'h0000, 16'h0000);

        // len=0 is a no-op that still reports done.
        cfg(14'h200, 0, 1, 8'h77);
        rem_e = '{0, 0, 0, 0};
        run(4, 16'h0001, 16'h0000, 16'h0000, 16'h0006, 16'h0004, 16'h0000, 16'h0000);

        // Range ending one past the last word is rejected.
        cfg(8190, 5, 1, 8'h66);
        rem_e = '{0, 0, 0, 0, 0};
        run(5, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0004, 16'h0000);

        // Range ending exactly on the last word is accepted.
        cfg(8190, 4, 1, 8'hC3);
        t0 = cycle;
        for (int i = 0; i < 4; i++) push_wr(8190 + i, 8'hC3, t0 + 2 + i);
        rem_e = '{0, 0, 4, 3, 2, 1, 0, 0};
        run(8, 16'h0001, 16'h0000, 16'h0000, 16'h007E, 16'h0040, 16'h0000, 16'h0000);

        // step=0 rewrites the base address.
        cfg(14'h010, 2, 0, 8'h42);
        t0 = cycle;
        push_wr(14'h010, 8'h42, t0 + 2);
        push_wr(14'h010, 8'h42, t0 + 3);
        rem_e = '{0, 0, 2, 1, 0, 0};
        run(6, 16'h0001, 16'h0000, 16'h0000, 16'h001E, 16'h0010, 16'h0000, 16'h0000);

        // Stride 40; a second start in cycle 3 with new config must be ignored.
        cfg(0, 3, 40, 8'h3C);
        t0 = cycle;
        push_wr(0, 8'h3C, t0 + 2);
        push_wr(40, 8'h3C, t0 + 3);
        push_wr(80, 8'h3C, t0 + 4);
        rem_e = '{0, 0};
        run(2, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000);
        cfg(14'h500, 1, 1, 8'hFF);
        rem_e = '{3, 2, 1, 0, 0, 0, 0};
        run(7, 16'h0002, 16'h0000, 16'h0000, 16'h000F, 16'h0008, 16'h0000, 16'h0000);

        // Abort in cycle 4 of a 10-word fill.
        cfg(14'h300, 10, 2, 8'h5A);
        t0 = cycle;
        for (int i = 0; i < 3; i++) push_wr(14'h300 + 2 * i, 8'h5A, t0 + 2 + i);
        rem_e = '{0, 0, 10, 9, 8};
        run(8, 16'h0001, 16'h0010, 16'h0000, 16'h001E, 16'h0000, 16'h0000, 16'h0020);

        // Abort together with start in IDLE: start is dropped.
        rem_e = '{};
        run(3, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Asynchronous reset in cycle 3 of a fill.
        cfg(14'h400, 10, 1, 8'h99);
        t0 = cycle;
        push_wr(14'h400, 8'h99, t0 + 2);
        rem_e = '{-1, -1, 10};
        run(3, 16'h0001, 16'h0000, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 16'h0000);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_vram_we", 32'(bus.vram_we), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        chk("arst_aborted", 32'(bus.aborted), 32'd0);
        chk("arst_remaining", 32'(bus.remaining), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rem_e = '{0, 0, 0, 0};
        run(4, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        chk("scoreboard_drained", 32'(eng_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
